servo_pwm_bank: RTL
===================

Name: servo_pwm_bank

Overview:
- Multi-channel, parametrised successor to the single-servo lock PWM driver.
- Drives NUM_CH hobby-servo PWM outputs from one shared 20 ms frame counter.
- Each channel takes a POS_W-bit target position and a per-channel enable.
- Position moves toward the target under a per-frame slew limit, so bolts and latches travel smoothly instead of snapping. Sits between the safe FSM and the actuator pins.

Parameters:
- NUM_CH, 2: number of servo channels.
- PERIOD_CYC, 1000000: clocks per PWM frame (20 ms at 50 MHz).
- MIN_PULSE, 50000: pulse width in clocks at position 0 (1.0 ms).
- PULSE_LSB, 196: added clocks per position step. MIN_PULSE + (2^POS_W-1)*PULSE_LSB must be <= MAX_PULSE.
- MAX_PULSE, 100000: hard ceiling on pulse width (2.0 ms).
- POS_W, 8: position width.
- SLEW, 8: max position steps applied per frame. SLEW=0 means an immediate jump.
- RESET_POS, 0: position loaded into target and current at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  one-cycle target write strobe
- wr_ch  in  $clog2(NUM_CH) (min 1)  channel index for the write
- wr_pos  in  POS_W  new target position
- ch_en  in  NUM_CH  per-channel output enable (level)
- servo  out  NUM_CH  registered PWM outputs
- moving  out  NUM_CH  1 while the channel's current position != target
- frame_tick  out  1  one-cycle pulse on the last clock of each frame

Behaviour:
- Reset (sync, rst=1 at a clk edge) clears the following:
  - counter=0; tgt[i]=cur[i]=RESET_POS; duty[i]=MIN_PULSE+RESET_POS*PULSE_LSB.
  - en_q[i]=0; servo=0; moving=0; frame_tick=0.
  - rst asserted mid-frame aborts the frame; the first post-reset frame starts with counter=0.
- Frame counter runs 0..PERIOD_CYC-1, then wraps to 0. It is free-running and independent of writes.
- Writes:
  - On wr_en=1 with wr_ch<NUM_CH, tgt[wr_ch] <= wr_pos on that edge.
  - wr_ch>=NUM_CH is ignored.
  - Back-to-back writes are allowed; the last one before a boundary wins.
- Frame boundary (counter==PERIOD_CYC-1), all channels updated on the same edge:
  - Boundary update uses tgt as registered before this edge. A write on the boundary cycle takes effect at the next boundary.
  - d = tgt-cur. If SLEW==0 or |d|<=SLEW, then cur<=tgt; else cur<=cur±SLEW toward tgt. No overshoot, no wrap-around.
  - duty <= min(MIN_PULSE + cur_next*PULSE_LSB, MAX_PULSE), computed at width $clog2(MAX_PULSE+1) with no truncation.
  - en_q <= ch_en. Enable changes are applied only at frame boundaries, so no runt or truncated pulses occur.
  - frame_tick=1 for exactly this one cycle, registered and aligned with the counter==PERIOD_CYC-1 cycle output.
- PWM output: servo[i] <= en_q[i] && (counter < duty[i]). This gives one clock of latency from counter to pin.
  - A disabled channel holds servo[i]=0 but still slews cur, so it resumes at the tracked position.
- moving[i] = registered (cur[i] != tgt[i]). It updates one cycle after either side changes.
- Glitch-free requirement: duty never changes within a frame, so every pulse is exactly duty clocks wide.

Decomposition:
- Package servo_pkg holds:
  - default timing constants (PERIOD_CYC, MIN_PULSE, MAX_PULSE, PULSE_LSB);
  - named positions (POS_LOCKED=0, POS_UNLOCKED=255);
  - a function pos_to_pulse(pos) that performs the clamp.
- Sub-module servo_channel, one instance per channel, generated:
  - holds tgt/cur/duty/en_q/moving;
  - takes the shared counter and boundary strobe;
  - produces one servo bit.
- The top holds the counter, the write decode and frame_tick.

Test Plan:
All scenarios use the small configuration PERIOD_CYC=100, MIN_PULSE=10, PULSE_LSB=1, MAX_PULSE=20, POS_W=4, SLEW=3, NUM_CH=2.
- Reset and idle: rst for 2 cycles, ch_en=0 -> servo=0, moving=0, frame_tick pulses every 100 cycles; after ch_en=3 and one boundary, both channels give 10-cycle pulses every 100 cycles.
- Slew: write ch0 pos=10 -> moving[0]=1; pulse widths 13, 16, 19, then clamp 20 (pos 10 → 20), then moving[0]=0; ch1 stays at 10.
- Clamp and decrease: write ch1 pos=15, then pos=2 mid-slew -> the later target wins; cur steps down by 3 per frame to exactly 2, pulse width 12, with no overshoot.
- Boundary-coincident write: write on the counter==99 cycle -> cur is unchanged at that boundary and changes at the next one.
- Enable mid-frame: drop ch_en[0] at counter=5 of a 10-wide pulse -> the current pulse completes at full width, the next frame is 0, and re-enable resumes at the slewed width.
- Reset mid-pulse and illegal channel: rst at counter=7 -> servo=0 on the next edge and positions return to RESET_POS; a write with wr_ch=1 is accepted, while wr_ch out of range (NUM_CH=2 with a wider index) changes nothing.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared timing defaults, named positions and the position-to-pulse clamp
// for the servo PWM bank.
package servo_pkg;

    localparam int unsigned PERIOD_CYC = 32'd1000000;
    localparam int unsigned MIN_PULSE  = 32'd50000;
    localparam int unsigned MAX_PULSE  = 32'd100000;
    localparam int unsigned PULSE_LSB  = 32'd196;

    localparam logic [7:0] POS_LOCKED   = 8'd0;
    localparam logic [7:0] POS_UNLOCKED = 8'd255;

    // Pulse width for a position, computed wide and clamped to the ceiling.
    function automatic logic [31:0] pos_to_pulse(
        input logic [31:0] pos,
        input logic [31:0] min_pulse,
        input logic [31:0] pulse_lsb,
        input logic [31:0] max_pulse
    );
        logic [63:0] raw_s;
        raw_s = 64'(min_pulse) + (64'(pos) * 64'(pulse_lsb));
        if (raw_s > 64'(max_pulse)) begin
            return max_pulse;
        end else begin
            return raw_s[31:0];
        end
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target/current position with per-frame slew, frame-latched
// duty and enable, and the registered PWM pin.
module servo_channel #(
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned POS_W     = 8,
    parameter int unsigned DUTY_W    = 17,
    parameter int unsigned MIN_PULSE = 50000,
    parameter int unsigned PULSE_LSB = 196,
    parameter int unsigned MAX_PULSE = 100000,
    parameter int unsigned SLEW      = 8,
    parameter int unsigned RESET_POS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic             wr_en,
    input  logic [POS_W-1:0] wr_pos,
    input  logic             en,
    input  logic [CNT_W-1:0] counter,
    output logic             servo,
    output logic             moving
);
    import servo_pkg::*;

    localparam int unsigned       CMP_W     = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;
    localparam logic [POS_W-1:0]  POS_RST   = POS_W'(RESET_POS);
    localparam logic [POS_W-1:0]  SLEW_STEP = POS_W'(SLEW);
    localparam logic [DUTY_W-1:0] DUTY_RST  =
        DUTY_W'(pos_to_pulse(32'(RESET_POS), MIN_PULSE, PULSE_LSB, MAX_PULSE));

    logic [POS_W-1:0]  tgt_r;
    logic [POS_W-1:0]  cur_r;
    logic [DUTY_W-1:0] duty_r;
    logic              en_q_r;
    logic              servo_r;
    logic              moving_r;
    logic [POS_W-1:0]  diff_s;
    logic [POS_W-1:0]  cur_next_s;
    logic [DUTY_W-1:0] duty_next_s;

    // Next position one slew step toward the target, never overshooting.
    always_comb begin
        cur_next_s = cur_r;
        diff_s     = '0;
        if (tgt_r > cur_r) begin
            diff_s = tgt_r - cur_r;
            if ((SLEW == 32'd0) || (32'(diff_s) <= SLEW)) begin
                cur_next_s = tgt_r;
            end else begin
                cur_next_s = cur_r + SLEW_STEP;
            end
        end else if (tgt_r < cur_r) begin
            diff_s = cur_r - tgt_r;
            if ((SLEW == 32'd0) || (32'(diff_s) <= SLEW)) begin
                cur_next_s = tgt_r;
            end else begin
                cur_next_s = cur_r - SLEW_STEP;
            end
        end else begin
            cur_next_s = cur_r;
        end
        duty_next_s = DUTY_W'(pos_to_pulse(32'(cur_next_s), MIN_PULSE, PULSE_LSB, MAX_PULSE));
    end

    // Target register; the last write before a boundary is the one used.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_r <= POS_RST;
        end else if (wr_en) begin
            tgt_r <= wr_pos;
        end else begin
            tgt_r <= tgt_r;
        end
    end

    // Position, duty and enable change only at a frame boundary, so pulses stay whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r  <= POS_RST;
            duty_r <= DUTY_RST;
            en_q_r <= 1'b0;
        end else if (boundary) begin
            cur_r  <= cur_next_s;
            duty_r <= duty_next_s;
            en_q_r <= en;
        end else begin
            cur_r  <= cur_r;
            duty_r <= duty_r;
            en_q_r <= en_q_r;
        end
    end

    // Registered PWM pin and moving flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            servo_r  <= 1'b0;
            moving_r <= 1'b0;
        end else begin
            servo_r  <= en_q_r && (CMP_W'(counter) < CMP_W'(duty_r));
            moving_r <= (cur_r != tgt_r);
        end
    end

    assign servo  = servo_r;
    assign moving = moving_r;

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM driver: shared frame counter, write decode and
// frame tick, with one slew-limited servo_channel per output.
module servo_pwm_bank #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned PERIOD_CYC = servo_pkg::PERIOD_CYC,
    parameter int unsigned MIN_PULSE  = servo_pkg::MIN_PULSE,
    parameter int unsigned PULSE_LSB  = servo_pkg::PULSE_LSB,
    parameter int unsigned MAX_PULSE  = servo_pkg::MAX_PULSE,
    parameter int unsigned POS_W      = 8,
    parameter int unsigned SLEW       = 8,
    parameter int unsigned RESET_POS  = 0,
    parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [POS_W-1:0]  wr_pos,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] servo,
    output logic [NUM_CH-1:0] moving,
    output logic              frame_tick
);
    import servo_pkg::*;

    localparam int unsigned      CNT_W    = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int unsigned      DUTY_W   = $clog2(MAX_PULSE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0] counter_r;
    logic [CNT_W-1:0] counter_next_s;
    logic             boundary_s;
    logic             wr_ok_s;
    logic             frame_tick_r;

    // Free-running frame counter wrap and in-range write qualification.
    always_comb begin
        boundary_s = (counter_r == CNT_LAST);
        if (boundary_s) begin
            counter_next_s = '0;
        end else begin
            counter_next_s = counter_r + CNT_W'(1);
        end
        wr_ok_s = wr_en && (32'(wr_ch) < NUM_CH);
    end

    // Counter and a tick that is high during the last cycle of every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_r    <= '0;
            frame_tick_r <= 1'b0;
        end else begin
            counter_r    <= counter_next_s;
            frame_tick_r <= (counter_next_s == CNT_LAST);
        end
    end

    assign frame_tick = frame_tick_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_channel #(
            .CNT_W    (CNT_W),
            .POS_W    (POS_W),
            .DUTY_W   (DUTY_W),
            .MIN_PULSE(MIN_PULSE),
            .PULSE_LSB(PULSE_LSB),
            .MAX_PULSE(MAX_PULSE),
            .SLEW     (SLEW),
            .RESET_POS(RESET_POS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .boundary(boundary_s),
            .wr_en   (wr_ok_s && (32'(wr_ch) == i)),
            .wr_pos  (wr_pos),
            .en      (ch_en[i]),
            .counter (counter_r),
            .servo   (servo[i]),
            .moving  (moving[i])
        );
    end

endmodule
